lane_fifo_ctrl: RTL and testbench
=================================

Name: lane_fifo_ctrl

Overview:
- Controller wrapping one lane_fifo RAM instance: a simple dual-port RAM with a registered read, 1-cycle read latency and old data on read-during-write.
- Turns the RAM into a first-word-fall-through lane FIFO with valid/ready handshakes on both sides.
- Owns the write/read pointers, the read-issue sequencing, a 2-entry output buffer and the fill level.
- Sits between a lane's hit-formatting stage and the packet scheduler's lane arbiter.

Parameters:
- DATA_WIDTH, 40, word width; passed to lane_fifo.
- ADDR_WIDTH, 9, RAM address width; DEPTH = 2**ADDR_WIDTH = 512 RAM entries.

Ports:
- clk  in  1  single clock for all logic and the RAM.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous clear of contents, same effect as reset; reset wins if both are high.
- in_data  in  DATA_WIDTH  write word.
- in_valid  in  1  write request.
- in_ready  out  1  high when the RAM is not full.
- out_data  out  DATA_WIDTH  head word, registered.
- out_valid  out  1  head word is valid.
- out_ready  in  1  consumer accepts the head word.
- usedw  out  ADDR_WIDTH+2  total words held: RAM + in-flight read + output buffer, 0..DEPTH+2.
- empty  out  1  high when usedw==0.

Behaviour:
- Pointers: wr_ptr and rd_ptr, each ADDR_WIDTH+1 bits, wrap naturally. RAM addresses are the low ADDR_WIDTH bits.
- ram_cnt = wr_ptr - rd_ptr, modulo arithmetic, range 0..DEPTH.
- Push = in_valid & in_ready.
  - in_ready = (ram_cnt != DEPTH), computed from registered pointers only; no dependence on out_ready.
  - On push: we=1, write_addr=wr_ptr[low], wr_ptr++.
- Read issue condition: ram_cnt != 0 AND (buf_cnt + rd_pend - pop) < 2, where pop = out_valid & out_ready.
  - ram_cnt uses the registered wr_ptr, so a read never targets the address written in the same cycle. The RAM's old-data read-during-write is therefore never exposed.
  - On issue: read_addr=rd_ptr[low], rd_ptr++, rd_pend<=1; otherwise rd_pend<=0.
- Output buffer: 2 entries, head and skid.
  - When rd_pend=1, RAM q is written at the edge into the head if the head is free after this cycle's pop, else into the skid.
  - On pop with the skid full, the skid moves to the head.
  - out_valid = (buf_cnt != 0).
- Latency: a push at edge 0 into an empty FIFO gives out_valid=1 after edge 2 (read issue in cycle 1, load at edge 2).
- Throughput: sustained 1 word/cycle with in_valid=out_ready=1 continuously.
- Simultaneous push and issue at any ram_cnt are both legal.
- usedw = ram_cnt + rd_pend + buf_cnt, registered-equivalent; updates one edge after the event.
- Full:
  - in_ready=0 at ram_cnt=DEPTH.
  - in_valid while full is ignored: no write, no pointer change, no error flag.
  - Maximum held is DEPTH+2 words, of which 2 are in the output buffer.
- Empty: out_valid=0; out_data holds its last value and is not cleared.
- Reset/flush values:
  - wr_ptr=rd_ptr=0, rd_pend=0, buf_cnt=0.
  - out_valid=0, in_ready=1, usedw=0, empty=1, out_data=0.
  - An in-flight RAM read is discarded.
  - RAM contents are not cleared.
  - A push presented in the flush cycle is dropped.
- Protocol: out_data and out_valid must stay stable while out_valid=1 and out_ready=0.

Decomposition:
- Shared package (lane_pkg): LANE_DATA_WIDTH=40, LANE_ADDR_WIDTH=9, LANE_OBUF_DEPTH=2.
- Single sub-module: lane_fifo, instantiated unmodified with DATA_WIDTH/ADDR_WIDTH passed through.
- All pointer, issue and buffer logic stays in lane_fifo_ctrl.

Test Plan:
- Single word: reset, push 0x00_0000_00A5 at edge 0, out_ready=1 -> out_valid rises after edge 2 with out_data=0xA5; one edge after the pop, usedw=0 and empty=1.
- Streaming: 1000 sequential words 0..999, in_valid=out_ready=1 -> outputs in order, no gaps after the first word, usedw never exceeds 3.
- Fill to full: out_ready=0, push 520 attempts -> 514 accepted (DEPTH+2), in_ready=0, usedw=514; then out_ready=1 -> words 0..513 in order and in_ready rises the cycle after the first RAM read issue.
- Backpressure stall: random out_ready (50%) with continuous pushes -> out_data stable while stalled, no loss or duplication, scoreboard order match.
- Pointer wrap: 3×DEPTH words with random in_valid/out_ready -> correct order across the rd_ptr/wr_ptr wrap, ram_cnt consistent.
- Flush mid-operation: hold 100 words, assert flush with in_valid=1 and a read in flight -> next cycle usedw=0, out_valid=0, in_ready=1; subsequent pushes 0x1,0x2 emerge as 0x1,0x2 with no stale data.

Source files
------------

// File: rtl/lane_pkg.sv
// Shared sizing constants for the lane FIFO controller and its RAM.
package lane_pkg;

    localparam int LANE_DATA_WIDTH = 40;
    localparam int LANE_ADDR_WIDTH = 9;
    localparam int LANE_OBUF_DEPTH = 2;
    localparam int LANE_OBUF_CNT_W = $clog2(LANE_OBUF_DEPTH + 1);

endpackage

// File: rtl/lane_fifo.sv
// Simple dual-port RAM: registered read, one-cycle latency, old data on read-during-write.
module lane_fifo #(
    parameter int DATA_WIDTH = 40,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[write_addr] <= data;
        end
        q <= mem[read_addr];
    end

endmodule

// File: rtl/lane_fifo_ctrl.sv
// First-word-fall-through lane FIFO built around lane_fifo: pointers, read issue,
// a two-entry head/skid output buffer and the fill level.
module lane_fifo_ctrl
    import lane_pkg::*;
#(
    parameter int DATA_WIDTH = LANE_DATA_WIDTH,
    parameter int ADDR_WIDTH = LANE_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH+1:0] usedw,
    output logic                  empty
);

    localparam int PTR_W  = ADDR_WIDTH + 1;
    localparam int USED_W = ADDR_WIDTH + 2;
    localparam int CNT_W  = LANE_OBUF_CNT_W;
    localparam logic [PTR_W-1:0] DEPTH_P = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [CNT_W-1:0]      buf_cnt_q, buf_cnt_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;

    logic [PTR_W-1:0]      ram_cnt;
    logic [CNT_W:0]        occ_after;
    logic [CNT_W-1:0]      buf_left;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic                  we;
    logic [DATA_WIDTH-1:0] ram_q;

    lane_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk        (clk),
        .we         (we),
        .write_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .data       (in_data),
        .read_addr  (rd_ptr_q[ADDR_WIDTH-1:0]),
        .q          (ram_q)
    );

    always_comb begin
        ram_cnt   = wr_ptr_q - rd_ptr_q;
        in_ready  = (ram_cnt != DEPTH_P);
        out_valid = (buf_cnt_q != '0);
        out_data  = head_q;
        empty     = (usedw == '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        // Occupancy the buffer will have once this cycle's pop and any landing read settle.
        occ_after = (CNT_W+1)'(buf_cnt_q) + (CNT_W+1)'(rd_pend_q) - (CNT_W+1)'(pop);
        issue     = (ram_cnt != '0) && (occ_after < (CNT_W+1)'(LANE_OBUF_DEPTH));
        buf_left  = buf_cnt_q - CNT_W'(pop);
        we        = push && !reset && !flush;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_pend_d = issue;
        buf_cnt_d = buf_left + CNT_W'(rd_pend_q);
        head_d    = head_q;
        skid_d    = skid_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (issue) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (pop && (buf_cnt_q == CNT_W'(2))) begin
            head_d = skid_q;
        end
        if (rd_pend_q) begin
            if (buf_left == '0) begin
                head_d = ram_q;
            end else begin
                skid_d = ram_q;
            end
        end

        if (reset || flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            rd_pend_d = 1'b0;
            buf_cnt_d = '0;
            head_d    = '0;
            skid_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q  <= wr_ptr_d;
        rd_ptr_q  <= rd_ptr_d;
        rd_pend_q <= rd_pend_d;
        buf_cnt_q <= buf_cnt_d;
        head_q    <= head_d;
        skid_q    <= skid_d;
    end

    assign usedw = USED_W'(ram_cnt) + USED_W'(rd_pend_q) + USED_W'(buf_cnt_q);

endmodule

// File: tb/tb_lane_fifo_ctrl.sv
// Scoreboard bench for lane_fifo_ctrl: a word queue models the FIFO contents.
module tb_lane_fifo_ctrl;
    import lane_pkg::*;

    localparam int DW    = LANE_DATA_WIDTH;
    localparam int AW    = LANE_ADDR_WIDTH;
    localparam int UW    = AW + 2;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          reset;
    logic          flush;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [UW-1:0] usedw;
    logic          empty;

    lane_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .usedw     (usedw),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            n_acc   = 0;
    int            n_pop   = 0;
    bit            mon_en  = 1'b0;
    logic [DW-1:0] model_q[$];
    bit            stall_prev = 1'b0;
    logic [DW-1:0] prev_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: checks level, stall stability and popped data against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("usedw", 64'(usedw), 64'(model_q.size()));
            chk("empty", 64'(empty), 64'(model_q.size() == 0));
            if (stall_prev) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_data", 64'(out_data), 64'(prev_data));
            end
            if (in_ready !== 1'b1) begin
                chk("ready_low_only_when_full", 64'(model_q.size() >= DEPTH), 64'd1);
            end
            if (reset || flush) begin
                model_q.delete();
                stall_prev = 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    if (model_q.size() == 0) begin
                        chk("pop_underflow", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        chk("pop_data", 64'(out_data), 64'(model_q.pop_front()));
                    end
                    n_pop++;
                end
                if (in_valid && in_ready) begin
                    model_q.push_back(in_data);
                    n_acc++;
                end
                stall_prev = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    task automatic drain(input string name);
        int cyc = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (model_q.size() != 0 && cyc < 3000) begin
            step();
            cyc++;
        end
        step();
        chk(name, 64'(model_q.size()), 64'd0);
        chk({name, "_empty"}, 64'(empty), 64'd1);
    endtask

    initial begin
        int acc_base;
        int pop_base;
        int sent;
        int gaps;
        int max_used;
        int cyc;
        bit seen;
        bit acc;
        logic [63:0] rnd;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) step();
        reset  = 1'b0;
        mon_en = 1'b1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_usedw", 64'(usedw), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_out_data", 64'(out_data), 64'd0);

        // Single word latency
        in_data = 40'hA5; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("lat_e0_valid", 64'(out_valid), 64'd0);
        step();
        chk("lat_e1_valid", 64'(out_valid), 64'd0);
        step();
        chk("lat_e2_valid", 64'(out_valid), 64'd1);
        chk("lat_e2_data", 64'(out_data), 64'hA5);
        step();
        chk("single_usedw", 64'(usedw), 64'd0);
        chk("single_empty", 64'(empty), 64'd1);

        // Streaming
        pop_base = n_pop; sent = 0; gaps = 0; max_used = 0; seen = 1'b0; cyc = 0;
        out_ready = 1'b1;
        while ((n_pop - pop_base) < 1000 && cyc < 1200) begin
            in_valid = (sent < 1000);
            in_data  = DW'(sent);
            acc = in_valid && in_ready;
            step();
            cyc++;
            if (acc) sent++;
            if (int'(usedw) > max_used) max_used = int'(usedw);
            if (out_valid) seen = 1'b1;
            if (seen && !out_valid && (n_pop - pop_base) < 1000) gaps++;
        end
        in_valid = 1'b0;
        chk("stream_count", 64'(n_pop - pop_base), 64'd1000);
        chk("stream_gaps", 64'(gaps), 64'd0);
        chk("stream_max_usedw_le3", 64'(max_used <= 3), 64'd1);
        drain("stream_drain");

        // Fill to full
        out_ready = 1'b0;
        acc_base = n_acc;
        for (int k = 0; k < 520; k++) begin
            in_valid = 1'b1;
            in_data  = DW'(n_acc - acc_base);
            step();
        end
        in_valid = 1'b0;
        chk("fill_accepted", 64'(n_acc - acc_base), 64'(DEPTH + 2));
        chk("fill_in_ready", 64'(in_ready), 64'd0);
        chk("fill_usedw", 64'(usedw), 64'(DEPTH + 2));
        out_ready = 1'b1;
        chk("fill_ready_before", 64'(in_ready), 64'd0);
        step();
        chk("fill_ready_rise", 64'(in_ready), 64'd1);
        drain("fill_drain");

        // Backpressure with random stalls
        for (int k = 0; k < 2000; k++) begin
            rnd       = {$urandom, $urandom};
            in_valid  = ($urandom % 8) != 0;
            in_data   = rnd[DW-1:0];
            out_ready = $urandom % 2;
            step();
        end
        drain("bp_drain");

        // Pointer wrap
        acc_base = n_acc; cyc = 0;
        while ((n_acc - acc_base) < 3 * DEPTH && cyc < 20000) begin
            rnd       = {$urandom, $urandom};
            in_valid  = $urandom % 2;
            in_data   = rnd[DW-1:0];
            out_ready = ($urandom % 3) != 0 ? ($urandom % 2) : 1'b0;
            step();
            cyc++;
        end
        chk("wrap_accepted", 64'((n_acc - acc_base) >= 3 * DEPTH), 64'd1);
        drain("wrap_drain");

        // Flush with a read in flight
        out_ready = 1'b0;
        for (int k = 0; k < 100; k++) begin
            in_valid = 1'b1;
            in_data  = DW'(1000 + k);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 40'hDEAD;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_usedw", 64'(usedw), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_out_data", 64'(out_data), 64'd0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 40'h1;
        step();
        in_data   = 40'h2;
        step();
        in_valid  = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            step();
            cyc++;
        end
        chk("flush_first_word", 64'(out_data), 64'h1);
        drain("flush_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
